vga_pattern_sched: RTL and testbench
====================================

// Module: vga_pattern_sched
// PURPOSE
//  Frame-synchronous scheduler for the VGA test-pattern generator. Sits beside vga_ctrl/vga_pic in vga_clk domain.
//  Detects frame start from vsync and drives pat_sel to the picture generator.
//  pat_sel changes only at frame boundaries, so no frame is ever torn.
//  Pattern changes come from auto-rotation every HOLD_FRAMES frames, a manual next pulse, or a req/ack config write.
// PARAMETERS
//  NUM_PAT      8   number of patterns; pat_sel range 0..NUM_PAT-1 (>=2)
//  PAT_W        3   width of pat_sel/cfg_pat; 2^PAT_W >= NUM_PAT
//  HOLD_FRAMES  60  frames each pattern is shown in auto mode (>=1; 0 illegal)
//  CNT_W        8   width of free-running frame counter
//  VS_POL       0   vsync active level; frame boundary = edge into VS_POL
// PORTS
//  vga_clk      in   1      pixel clock, all logic rising-edge
//  sys_rst      in   1      asynchronous, active-high reset
//  vsync        in   1      vsync from vga_ctrl (same clock domain)
//  en           in   1      scheduler enable (level)
//  pause        in   1      freeze auto-rotation (level, sampled at frame boundary)
//  next_req     in   1      1-cycle pulse: advance one pattern at next frame boundary
//  cfg_req      in   1      config request, held high until cfg_ack
//  cfg_pat      in   PAT_W  requested pattern, stable while cfg_req high
//  cfg_ack      out  1      1-cycle pulse: cfg_pat applied
//  pat_sel      out  PAT_W  current pattern to vga_pic
//  frame_start  out  1      1-cycle pulse per detected frame boundary
//  frame_cnt    out  CNT_W  frames seen while en=1, wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset (async, immediate): pat_sel=0, cfg_ack=0, frame_start=0, frame_cnt=0, state=WAIT, hold_cnt=0,
//    next_pend=0, vs_d=VS_POL (so vsync already at VS_POL on release gives no false frame).
//  - fs = (vsync==VS_POL) && (vs_d!=VS_POL); vs_d<=vsync each cycle. All outputs registered: frame_start,
//    pat_sel, cfg_ack update on the edge ending the fs cycle (1 clk after vsync edge seen at input).
//  - en=0: state->WAIT, hold_cnt=0, next_pend=0, frame_cnt held, pat_sel held, fs produces no frame_start, no ack.
//  - FSM (evaluated only on fs with en=1): WAIT -> RUN on first fs, no advance on that fs (cfg still applies).
//    RUN -> PAUSED if pause=1 at fs; PAUSED -> RUN if pause=0 at fs. Advance decision uses pre-transition state.
//  - next_pend set by next_req (any state, en=1); pulses in one frame collapse to one; next_req in fs cycle counts.
//  - At fs, exactly one action, priority: (1) cfg_req=1 -> pat_sel=cfg_pat, clamped to NUM_PAT-1 if larger,
//    cfg_ack=1 for that one cycle; (2) next_pend|next_req -> pat_sel+1; (3) RUN and hold_cnt==HOLD_FRAMES-1
//    -> pat_sel+1; else RUN: hold_cnt+1. PAUSED: hold_cnt frozen.
//  - Any advance or cfg apply: hold_cnt=0, next_pend=0 (cfg discards pending next). Increment wraps NUM_PAT-1->0.
//  - cfg applies in WAIT, RUN, PAUSED. cfg_req sampled only at fs; requester drops it the cycle after cfg_ack;
//    still high at a later fs = new request.
//  - frame_cnt+1 on every fs with en=1, modulo 2^CNT_W.
//  - sys_rst mid-frame: pending cfg/next lost, no ack ever issued for that request.
// TESTING (NUM_PAT=5, HOLD_FRAMES=3, VS_POL=0, en=1)
//  1 reset, free-run 20 frames -> 1st fs: pat 0 (WAIT->RUN); pat=1 at fs#4, 2 at #7 ... 4->0 wrap at #16; frame_cnt=20.
//  2 pause=1 before fs#3 -> pat frozen 5 frames; pause=0 -> resumes, advance after remaining hold_cnt frames only.
//  3 cfg_req, cfg_pat=3 mid-frame -> at next fs pat_sel=3 and cfg_ack=1 same cycle, 1 cycle wide; cfg_pat=7 -> pat_sel=4.
//  4 cfg_req(2) and next_req same frame -> pat_sel=2, next dropped; following frames no extra advance.
//  5 PAUSED, 3 next_req pulses in one frame -> exactly +1 at next fs; next_req in fs cycle -> applied that fs.
//  6 sys_rst mid-frame with cfg pending, vsync held 0 across release -> all outputs 0 at once, no frame_start, no cfg_ack.

Source files
------------

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler: picks pat_sel for vga_pic and only
// changes it on a vsync frame boundary (auto-rotate, manual next, or cfg write).
module vga_pattern_sched #(
  parameter int   NUM_PAT     = 8,
  parameter int   PAT_W       = 3,
  parameter int   HOLD_FRAMES = 60,
  parameter int   CNT_W       = 8,
  parameter logic VS_POL      = 1'b0
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic             vsync,
  input  logic             en,
  input  logic             pause,
  input  logic             next_req,
  input  logic             cfg_req,
  input  logic [PAT_W-1:0] cfg_pat,
  output logic             cfg_ack,
  output logic [PAT_W-1:0] pat_sel,
  output logic             frame_start,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PAT_W-1:0]  PAT_MAX   = PAT_W'(NUM_PAT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              vs_d_r;
  logic              fs_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic              next_pend_r, next_pend_nxt_s;
  logic [PAT_W-1:0]  pat_nxt_s;
  logic              ack_nxt_s;
  logic              fstart_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;

  function automatic logic [PAT_W-1:0] pat_inc(input logic [PAT_W-1:0] p);
    if (p >= PAT_MAX) return {PAT_W{1'b0}};
    else              return p + PAT_W'(1);
  endfunction

  function automatic logic [PAT_W-1:0] pat_clamp(input logic [PAT_W-1:0] p);
    if (p > PAT_MAX) return PAT_MAX;
    else             return p;
  endfunction

  // Frame boundary: vsync enters its active level this cycle.
  assign fs_s = (vsync == VS_POL) && (vs_d_r != VS_POL);

  // State and datapath registers.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r     <= ST_WAIT;
      vs_d_r      <= VS_POL;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      next_pend_r <= 1'b0;
      pat_sel     <= {PAT_W{1'b0}};
      cfg_ack     <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      vs_d_r      <= vsync;
      hold_cnt_r  <= hold_cnt_nxt_s;
      next_pend_r <= next_pend_nxt_s;
      pat_sel     <= pat_nxt_s;
      cfg_ack     <= ack_nxt_s;
      frame_start <= fstart_nxt_s;
      frame_cnt   <= cnt_nxt_s;
    end
  end

  // Next-state logic: mode only moves on an enabled frame boundary.
  always_comb begin
    state_nxt_s = state_r;
    if (!en) begin
      state_nxt_s = ST_WAIT;
    end else if (fs_s) begin
      case (state_r)
        ST_WAIT:   state_nxt_s = ST_RUN;
        ST_RUN:    state_nxt_s = pause ? ST_PAUSED : ST_RUN;
        ST_PAUSED: state_nxt_s = pause ? ST_PAUSED : ST_RUN;
        default:   state_nxt_s = ST_WAIT;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output/datapath logic; the action at a boundary uses the pre-transition state.
  always_comb begin
    pat_nxt_s       = pat_sel;
    ack_nxt_s       = 1'b0;
    fstart_nxt_s    = 1'b0;
    cnt_nxt_s       = frame_cnt;
    hold_cnt_nxt_s  = hold_cnt_r;
    next_pend_nxt_s = next_pend_r;
    if (!en) begin
      hold_cnt_nxt_s  = {HOLD_W{1'b0}};
      next_pend_nxt_s = 1'b0;
    end else if (!fs_s) begin
      next_pend_nxt_s = next_pend_r | next_req;
    end else begin
      fstart_nxt_s    = 1'b1;
      cnt_nxt_s       = frame_cnt + CNT_W'(1);
      next_pend_nxt_s = 1'b0;
      if (cfg_req) begin
        pat_nxt_s      = pat_clamp(cfg_pat);
        ack_nxt_s      = 1'b1;
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
      end else if (next_pend_r || next_req) begin
        pat_nxt_s      = pat_inc(pat_sel);
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
      end else if (state_r == ST_RUN) begin
        if (hold_cnt_r == HOLD_LAST) begin
          pat_nxt_s      = pat_inc(pat_sel);
          hold_cnt_nxt_s = {HOLD_W{1'b0}};
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end
      end else begin
        hold_cnt_nxt_s = hold_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_sched.sv
// Directed bench for vga_pattern_sched with a frame-level reference model
// compared every cycle, plus literal checkpoints from hand-worked scenarios.
module tb_vga_pattern_sched;

  localparam int NUM = 5;
  localparam int HOLD = 3;

  logic       vga_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       vsync = 1'b1;
  logic       en = 1'b1;
  logic       pause = 1'b0;
  logic       next_req = 1'b0;
  logic       cfg_req = 1'b0;
  logic [2:0] cfg_pat = 3'd0;
  logic       cfg_ack;
  logic [2:0] pat_sel;
  logic       frame_start;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;
  bit fs_next = 1'b0;

  vga_pattern_sched #(
    .NUM_PAT(NUM), .PAT_W(3), .HOLD_FRAMES(HOLD), .CNT_W(8), .VS_POL(1'b0)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .vsync(vsync), .en(en), .pause(pause),
    .next_req(next_req), .cfg_req(cfg_req), .cfg_pat(cfg_pat), .cfg_ack(cfg_ack),
    .pat_sel(pat_sel), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference model: tracks frames shown of the current pattern and mode flags.
  int m_pat, m_cnt, m_shown;
  bit m_started, m_frozen, m_next, m_vs, m_fs_o, m_ack, m_edge;
  always @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_pat = 0; m_cnt = 0; m_shown = 0; m_started = 0; m_frozen = 0;
      m_next = 0; m_vs = 0; m_fs_o = 0; m_ack = 0;
    end else begin
      m_edge = (vsync == 1'b0) && m_vs;
      m_vs = vsync;
      m_fs_o = 0;
      m_ack = 0;
      if (!en) begin
        m_started = 0; m_frozen = 0; m_shown = 0; m_next = 0;
      end else if (!m_edge) begin
        m_next = m_next | next_req;
      end else begin
        m_fs_o = 1;
        m_cnt = (m_cnt + 1) % 256;
        if (cfg_req) begin
          m_pat = (cfg_pat >= NUM) ? NUM - 1 : int'(cfg_pat);
          m_ack = 1;
          m_shown = 0;
        end else if (!m_started) begin
          m_shown = 0;
        end else if (m_next || next_req) begin
          m_pat = (m_pat + 1) % NUM;
          m_shown = 0;
        end else if (!m_frozen) begin
          m_shown = m_shown + 1;
          if (m_shown == HOLD) begin
            m_pat = (m_pat + 1) % NUM;
            m_shown = 0;
          end
        end
        m_next = 0;
        if (!m_started) m_started = 1;
        else m_frozen = pause;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge vga_clk) begin
    n_cmp = n_cmp + 1;
    if (pat_sel !== 3'(m_pat) || frame_cnt !== 8'(m_cnt) ||
        frame_start !== m_fs_o || cfg_ack !== m_ack) begin
      n_err = n_err + 1;
      $display("FAIL cycle t=%0t pat %0d/%0d cnt %0d/%0d fs %0b/%0b ack %0b/%0b (got/exp)",
               $time, pat_sel, m_pat, frame_cnt, m_cnt, frame_start, m_fs_o, cfg_ack, m_ack);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive vsync by frame phase (6 high, 2 low); requester drops cfg_req after ack.
  task automatic tick();
    @(posedge vga_clk);
    #2;
    next_req = fs_next && (phase == 6);
    vsync = (phase < 6);
    if (cfg_ack) cfg_req = 1'b0;
    phase = (phase + 1) % 8;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frames(input int n);
    ticks(8 * n);
  endtask

  task automatic pulse_next();
    next_req = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    @(posedge vga_clk);
    #2;
    sys_rst = 1'b1; vsync = 1'b1; pause = 1'b0; cfg_req = 1'b0; next_req = 1'b0;
    fs_next = 1'b0; phase = 0;
    @(posedge vga_clk);
    @(posedge vga_clk);
    #2;
    sys_rst = 1'b0;
  endtask

  int fs_seen, ack_seen;

  initial begin
    #1 sys_rst = 1'b1;
    do_reset();
    check("reset_pat", int'(pat_sel), 0);
    check("reset_cnt", int'(frame_cnt), 0);

    // 1: free run
    frames(1);
    check("t1_fs1_pat", int'(pat_sel), 0);
    check("t1_fs1_start", int'(frame_start), 1);
    frames(3);
    check("t1_fs4_pat", int'(pat_sel), 1);
    frames(3);
    check("t1_fs7_pat", int'(pat_sel), 2);
    frames(8);
    check("t1_fs15_pat", int'(pat_sel), 4);
    frames(1);
    check("t1_fs16_wrap", int'(pat_sel), 0);
    frames(4);
    check("t1_cnt20", int'(frame_cnt), 20);
    check("t1_fs20_pat", int'(pat_sel), 1);

    // 2: pause before fs#3 for 5 frames
    do_reset();
    frames(2);
    pause = 1'b1;
    frames(5);
    check("t2_paused_pat", int'(pat_sel), 0);
    pause = 1'b0;
    frames(1);
    check("t2_fs8_pat", int'(pat_sel), 0);
    frames(1);
    check("t2_fs9_pat", int'(pat_sel), 1);

    // 3: cfg write, then clamped cfg write
    do_reset();
    frames(2);
    ticks(2);
    cfg_req = 1'b1; cfg_pat = 3'd3;
    ticks(6);
    check("t3_pat3", int'(pat_sel), 3);
    check("t3_ack", int'(cfg_ack), 1);
    tick();
    check("t3_ack_width", int'(cfg_ack), 0);
    check("t3_req_dropped", int'(cfg_req), 0);
    ticks(2);
    cfg_req = 1'b1; cfg_pat = 3'd7;
    ticks(5);
    check("t3_clamp", int'(pat_sel), 4);

    // 4: cfg and next in the same frame
    do_reset();
    frames(2);
    ticks(1);
    cfg_req = 1'b1; cfg_pat = 3'd2;
    pulse_next();
    ticks(6);
    check("t4_cfg_wins", int'(pat_sel), 2);
    frames(2);
    check("t4_no_extra", int'(pat_sel), 2);
    frames(1);
    check("t4_auto_adv", int'(pat_sel), 3);

    // 5: paused next pulses collapse; pulse in the fs cycle counts
    do_reset();
    frames(1);
    pause = 1'b1;
    frames(1);
    ticks(1);
    pulse_next(); tick(); pulse_next(); tick(); pulse_next();
    ticks(2);
    check("t5_collapse", int'(pat_sel), 1);
    frames(1);
    check("t5_paused_hold", int'(pat_sel), 1);
    fs_next = 1'b1;
    frames(1);
    fs_next = 1'b0;
    check("t5_fs_cycle_next", int'(pat_sel), 2);
    frames(1);
    check("t5_after", int'(pat_sel), 2);

    // 6: reset mid-frame with cfg pending, vsync low across release
    pause = 1'b0;
    ticks(2);
    cfg_req = 1'b1; cfg_pat = 3'd4;
    ticks(2);
    @(posedge vga_clk);
    #3;
    vsync = 1'b0; sys_rst = 1'b1; cfg_req = 1'b0;
    #1;
    check("t6_rst_pat", int'(pat_sel), 0);
    check("t6_rst_cnt", int'(frame_cnt), 0);
    check("t6_rst_ack", int'(cfg_ack), 0);
    @(posedge vga_clk);
    @(posedge vga_clk);
    #2;
    sys_rst = 1'b0;
    fs_seen = 0; ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge vga_clk);
      #2;
      fs_seen += int'(frame_start);
      ack_seen += int'(cfg_ack);
    end
    check("t6_no_fs", fs_seen, 0);
    check("t6_no_ack", ack_seen, 0);
    phase = 0;
    frames(1);
    check("t6_first_frame_cnt", int'(frame_cnt), 1);
    check("t6_first_frame_pat", int'(pat_sel), 0);

    // en=0 holds counters and suppresses frame_start
    en = 1'b0;
    frames(2);
    check("en0_cnt_held", int'(frame_cnt), 1);
    en = 1'b1;
    frames(1);
    check("en1_cnt", int'(frame_cnt), 2);

    ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
